// File: rtl/mem_access_unit.sv
// Shared instruction/data memory port for the multi-cycle RV32I core.
// Runs one valid/ready bus transaction per request and stalls the control FSM until it completes.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetch_req,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              err_clr,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] old_pc,
  output logic [DATA_W-1:0] rdata,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic              err_multi,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_d, rdata_d, bus_wdata_d;
  logic [ADDR_W-1:0] old_pc_d, bus_addr_d;
  logic              bus_valid_d, bus_we_d;
  logic              set_misalign, set_timeout, set_multi;
  logic              req_any, req_multi, aligned;

  assign req_any   = fetch_req | rd_req | wr_req;
  assign req_multi = (fetch_req & rd_req) | (fetch_req & wr_req) | (rd_req & wr_req);
  assign aligned   = (addr[1:0] == 2'b00);

  // Combinational so the FSM holds in the very cycle it raises a strobe.
  assign stall = (state_q != IDLE) || (req_any && aligned);

  // Next-state and next-register values.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    instr_d      = instr;
    old_pc_d     = old_pc;
    rdata_d      = rdata;
    bus_valid_d  = bus_valid;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    set_misalign = 1'b0;
    set_timeout  = 1'b0;
    set_multi    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          set_multi = req_multi;
          if (!aligned) begin
            set_misalign = 1'b1;
          end else begin
            state_d     = REQ;
            kind_d      = fetch_req ? K_FETCH : (rd_req ? K_READ : K_WRITE);
            pc_d        = pc_in;
            bus_valid_d = 1'b1;
            bus_we_d    = !fetch_req && !rd_req;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = wdata;
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          cnt_d       = '0;
          state_d     = (kind_q == K_WRITE) ? IDLE : RSP;
        end
      end
      RSP: begin
        if (bus_rsp_valid) begin
          if (kind_q == K_FETCH) begin
            instr_d  = bus_rdata;
            old_pc_d = pc_q;
          end else begin
            rdata_d = bus_rdata;
          end
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          set_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; a set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      kind_q       <= K_FETCH;
      pc_q         <= '0;
      cnt_q        <= '0;
      instr        <= NOP;
      old_pc       <= '0;
      rdata        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      err_multi    <= 1'b0;
      bus_valid    <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      instr        <= instr_d;
      old_pc       <= old_pc_d;
      rdata        <= rdata_d;
      err_misalign <= set_misalign | (err_misalign & ~err_clr);
      err_timeout  <= set_timeout  | (err_timeout  & ~err_clr);
      err_multi    <= set_multi    | (err_multi    & ~err_clr);
      bus_valid    <= bus_valid_d;
      bus_we       <= bus_we_d;
      bus_addr     <= bus_addr_d;
      bus_wdata    <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a bus responder with programmable delays plus a
// transaction-level model of the captured registers and sticky error flags.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rstn;
  logic        fetch_req, rd_req, wr_req, err_clr;
  logic [31:0] addr, wdata, pc_in;
  logic        stall;
  logic [31:0] instr, old_pc, rdata;
  logic        err_misalign, err_timeout, err_multi;
  logic        bus_valid, bus_ready, bus_we, bus_rsp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model of the architecturally visible registers.
  logic [31:0] m_instr, m_old_pc, m_rdata;
  logic        m_mis, m_to, m_multi;

  // Observations returned by run_access.
  int          o_stall;
  bit          o_hung, o_stable;
  logic        o_we;
  logic [31:0] o_addr, o_wdata;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .fetch_req(fetch_req), .rd_req(rd_req), .wr_req(wr_req),
    .addr(addr), .wdata(wdata), .pc_in(pc_in), .err_clr(err_clr), .stall(stall),
    .instr(instr), .old_pc(old_pc), .rdata(rdata), .err_misalign(err_misalign),
    .err_timeout(err_timeout), .err_multi(err_multi), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_instr = NOP; m_old_pc = '0; m_rdata = '0;
    m_mis = 1'b0; m_to = 1'b0; m_multi = 1'b0;
  endtask

  // Issues one request for a single cycle and plays the bus slave. While the
  // unit is busy it injects spurious requests and out-of-window responses.
  task automatic run_access(input logic [2:0] req, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] pc, input int rdy_dly, input int rsp_dly,
                            input bit give_rsp, input logic [31:0] data);
    int  vcnt, acc_cyc;
    bit  accepted, is_read, seen;
    is_read = req[0] | req[1];
    vcnt = 0; acc_cyc = 0; accepted = 0; seen = 0;
    o_hung = 1; o_stable = 1; o_we = 1'bx; o_addr = 'x; o_wdata = 'x;
    @(negedge clk);
    {wr_req, rd_req, fetch_req} = req;
    addr = a; wdata = wd; pc_in = pc;
    bus_ready = 0; bus_rsp_valid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    #1 o_stall = stall ? 1 : 0;
    for (int k = 1; k < 60; k++) begin
      @(negedge clk);
      fetch_req = 0; rd_req = 0; wr_req = 0;
      bus_ready = 0; bus_rsp_valid = 0; bus_rdata = $urandom;
      if (bus_valid && !accepted) begin
        if (!seen) begin
          seen = 1; o_we = bus_we; o_addr = bus_addr; o_wdata = bus_wdata;
        end else if (bus_we !== o_we || bus_addr !== o_addr || bus_wdata !== o_wdata) begin
          o_stable = 0;
        end
        bus_rsp_valid = 1'($urandom_range(0, 1));
        if (vcnt == rdy_dly) begin
          bus_ready = 1; accepted = 1; acc_cyc = k;
        end
        vcnt++;
      end else if (accepted && is_read && give_rsp && k == acc_cyc + 1 + rsp_dly) begin
        bus_rsp_valid = 1; bus_rdata = data;
      end
      #1;
      if (!stall) begin
        o_hung = 0;
        break;
      end
      o_stall++;
      fetch_req = 1'($urandom_range(0, 1)); rd_req = 1'($urandom_range(0, 1));
      wr_req = 1'($urandom_range(0, 1));
      addr = $urandom; pc_in = $urandom; wdata = $urandom;
    end
    fetch_req = 0; rd_req = 0; wr_req = 0; bus_ready = 0; bus_rsp_valid = 0;
  endtask

  task automatic test_reset();
    rstn = 0; fetch_req = 0; rd_req = 0; wr_req = 0; err_clr = 0;
    addr = '0; wdata = '0; pc_in = '0; bus_ready = 0; bus_rsp_valid = 0; bus_rdata = '0;
    model_reset();
    #12;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_cmp++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
    n_cmp++; if (old_pc !== 32'h0) begin n_fail++; $display("FAIL reset_old_pc got %h exp 0", old_pc); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_cmp++; if ({err_misalign, err_timeout, err_multi} !== 3'b000) begin
      n_fail++; $display("FAIL reset_err got %b exp 000", {err_misalign, err_timeout, err_multi}); end
    n_cmp++; if ({bus_valid, bus_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_bus_ctl got %b exp 00", {bus_valid, bus_we}); end
    n_cmp++; if ({bus_addr, bus_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus_data got %h %h exp 0 0", bus_addr, bus_wdata); end
    @(negedge clk) rstn = 1;
  endtask

  task automatic test_fetch();
    run_access(3'b001, 32'h100, 32'h0, 32'h100, 0, 0, 1, 32'h0050_0093);
    m_instr = 32'h0050_0093; m_old_pc = 32'h100;
    n_cmp++; if (o_hung || o_stall != 3) begin
      n_fail++; $display("FAIL fetch_stall_cycles got %0d (hung %0d) exp 3", o_stall, o_hung); end
    n_cmp++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin
      n_fail++; $display("FAIL fetch_bus got addr %h we %b exp 100 0", o_addr, o_we); end
    n_cmp++; if (instr !== m_instr || old_pc !== m_old_pc) begin
      n_fail++; $display("FAIL fetch_ir got %h/%h exp %h/%h", instr, old_pc, m_instr, m_old_pc); end
  endtask

  task automatic test_load();
    run_access(3'b010, 32'h2004, 32'h0, 32'h44, 3, 2, 1, 32'hCAFE_F00D);
    m_rdata = 32'hCAFE_F00D;
    n_cmp++; if (o_hung || o_stall != 8) begin
      n_fail++; $display("FAIL load_stall_cycles got %0d (hung %0d) exp 8", o_stall, o_hung); end
    n_cmp++; if (o_addr !== 32'h2004 || o_we !== 1'b0 || !o_stable) begin
      n_fail++; $display("FAIL load_bus got addr %h we %b stable %0d exp 2004 0 1", o_addr, o_we, o_stable); end
    n_cmp++; if (rdata !== m_rdata || instr !== m_instr || old_pc !== m_old_pc) begin
      n_fail++; $display("FAIL load_regs got %h %h %h exp %h %h %h", rdata, instr, old_pc, m_rdata, m_instr, m_old_pc); end
  endtask

  task automatic test_store();
    run_access(3'b100, 32'h3000, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 32'h0);
    n_cmp++; if (o_hung || o_stall != 2) begin
      n_fail++; $display("FAIL store_stall_cycles got %0d (hung %0d) exp 2", o_stall, o_hung); end
    n_cmp++; if (o_addr !== 32'h3000 || o_we !== 1'b1 || o_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_bus got %h %b %h exp 3000 1 deadbeef", o_addr, o_we, o_wdata); end
    n_cmp++; if (rdata !== m_rdata || instr !== m_instr) begin
      n_fail++; $display("FAIL store_regs got %h %h exp %h %h", rdata, instr, m_rdata, m_instr); end
  endtask

  task automatic test_random();
    logic [31:0] a, pc, wd, d;
    int kind, rdy, rsp, exp_stall;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom; a[1:0] = 2'b00;
      pc = $urandom; wd = $urandom; d = $urandom;
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, TO - 1);
      run_access(3'b001 << kind, a, wd, pc, rdy, rsp, 1, d);
      exp_stall = (kind == 2) ? 2 + rdy : 3 + rdy + rsp;
      if (kind == 0) begin m_instr = d; m_old_pc = pc; end
      if (kind == 1) m_rdata = d;
      n_cmp++; if (o_hung || o_stall != exp_stall) begin
        n_fail++; $display("FAIL rand%0d_stall got %0d (hung %0d) exp %0d", i, o_stall, o_hung, exp_stall); end
      n_cmp++; if (o_addr !== a || o_we !== (kind == 2) || !o_stable || (kind == 2 && o_wdata !== wd)) begin
        n_fail++; $display("FAIL rand%0d_bus got %h %b %h st%0d exp %h %b %h", i, o_addr, o_we, o_wdata, o_stable, a, kind == 2, wd); end
      n_cmp++; if (instr !== m_instr || old_pc !== m_old_pc || rdata !== m_rdata) begin
        n_fail++; $display("FAIL rand%0d_regs got %h %h %h exp %h %h %h", i, instr, old_pc, rdata, m_instr, m_old_pc, m_rdata); end
      n_cmp++; if ({err_misalign, err_timeout, err_multi} !== {m_mis, m_to, m_multi}) begin
        n_fail++; $display("FAIL rand%0d_err got %b exp %b", i, {err_misalign, err_timeout, err_multi}, {m_mis, m_to, m_multi}); end
    end
  endtask

  task automatic test_misalign();
    @(negedge clk); rd_req = 1; addr = 32'h2002;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL misalign_stall got %b exp 0", stall); end
    @(negedge clk); rd_req = 0;
    m_mis = 1;
    #1;
    n_cmp++; if (bus_valid !== 1'b0 || err_misalign !== 1'b1) begin
      n_fail++; $display("FAIL misalign_flag got valid %b err %b exp 0 1", bus_valid, err_misalign); end
    n_cmp++; if (rdata !== m_rdata || stall !== 1'b0) begin
      n_fail++; $display("FAIL misalign_regs got %h stall %b exp %h 0", rdata, stall, m_rdata); end
  endtask

  task automatic test_multi();
    run_access(3'b101, 32'h500, 32'h1234_5678, 32'h4FC, 1, 1, 1, 32'h00A0_0113);
    m_instr = 32'h00A0_0113; m_old_pc = 32'h4FC; m_multi = 1;
    n_cmp++; if (o_we !== 1'b0 || o_stall != 5 || err_multi !== 1'b1) begin
      n_fail++; $display("FAIL multi_fetch_wins got we %b stall %0d err %b exp 0 5 1", o_we, o_stall, err_multi); end
    n_cmp++; if (instr !== m_instr || old_pc !== m_old_pc) begin
      n_fail++; $display("FAIL multi_ir got %h %h exp %h %h", instr, old_pc, m_instr, m_old_pc); end
    run_access(3'b110, 32'h600, 32'h0, 32'h0, 0, 0, 1, 32'h7777_0000);
    m_rdata = 32'h7777_0000;
    n_cmp++; if (o_we !== 1'b0 || rdata !== m_rdata) begin
      n_fail++; $display("FAIL multi_read_wins got we %b rdata %h exp 0 %h", o_we, rdata, m_rdata); end
  endtask

  task automatic test_err_clr();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    m_mis = 0; m_to = 0; m_multi = 0;
    n_cmp++; if ({err_misalign, err_timeout, err_multi} !== 3'b000) begin
      n_fail++; $display("FAIL clr_all got %b exp 000", {err_misalign, err_timeout, err_multi}); end
    // Set and clear in the same cycle: the set survives.
    @(negedge clk); err_clr = 1; wr_req = 1; addr = 32'h3001;
    @(negedge clk); err_clr = 0; wr_req = 0;
    m_mis = 1;
    n_cmp++; if ({err_misalign, err_timeout, err_multi} !== 3'b100) begin
      n_fail++; $display("FAIL clr_set_wins got %b exp 100", {err_misalign, err_timeout, err_multi}); end
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    m_mis = 0;
  endtask

  task automatic test_timeout();
    run_access(3'b010, 32'h2008, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    m_to = 1;
    n_cmp++; if (o_hung || o_stall != 2 + 1 + TO) begin
      n_fail++; $display("FAIL timeout_cycles got %0d (hung %0d) exp %0d", o_stall, o_hung, 2 + 1 + TO); end
    n_cmp++; if (err_timeout !== 1'b1 || rdata !== m_rdata) begin
      n_fail++; $display("FAIL timeout_flag got err %b rdata %h exp 1 %h", err_timeout, rdata, m_rdata); end
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    m_to = 0;
    // Response in the last allowed RSP cycle is still taken.
    run_access(3'b010, 32'h200C, 32'h0, 32'h0, 0, TO - 1, 1, 32'h5A5A_A5A5);
    m_rdata = 32'h5A5A_A5A5;
    n_cmp++; if (err_timeout !== 1'b0 || rdata !== m_rdata || o_stall != 3 + TO - 1) begin
      n_fail++; $display("FAIL timeout_edge got err %b rdata %h stall %0d exp 0 %h %0d", err_timeout, rdata, o_stall, m_rdata, 3 + TO - 1); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); fetch_req = 1; addr = 32'h400; pc_in = 32'h400;
    @(negedge clk); fetch_req = 0;
    n_cmp++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_req got %b exp 1", bus_valid); end
    #3 rstn = 0;
    model_reset();
    #1;
    n_cmp++; if (bus_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_drop got valid %b stall %b exp 0 0", bus_valid, stall); end
    n_cmp++; if (instr !== m_instr || old_pc !== m_old_pc || rdata !== m_rdata) begin
      n_fail++; $display("FAIL rstmid_regs got %h %h %h exp %h 0 0", instr, old_pc, rdata, m_instr); end
    @(negedge clk); rstn = 1;
    @(negedge clk); bus_rsp_valid = 1; bus_ready = 1; bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk); bus_rsp_valid = 0; bus_ready = 0;
    #1;
    n_cmp++; if (instr !== m_instr || rdata !== m_rdata || stall !== 1'b0 || bus_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_late_rsp got %h %h %b %b exp %h %h 0 0", instr, rdata, stall, bus_valid, m_instr, m_rdata); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_random();
    test_misalign();
    test_multi();
    test_err_clr();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
